// File: rtl/pong_vga_sync.sv
// pong_vga_sync: VGA scan timing generator (pixel divider, h/v counters, sync, strobes).
// Ports: clk, reset (sync, active-high); pixel_x/pixel_y scan position; p_tick/l_tick/f_tick
//   pixel/line/frame strobes; hsync/vsync at SYNC_POL; video_on inside visible area.
// Optional macro PONG_SYNC_PIPE_EN: delays hsync/vsync/video_on by one extra clk register stage.
module pong_vga_sync #(
  parameter int DIV      = 4,
  parameter int H_DISP   = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_DISP   = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       p_tick,
  output logic       l_tick,
  output logic       f_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on
);

  localparam int H_TOT = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int DW    = (DIV > 2) ? $clog2(DIV) : 1;

  if (H_TOT > 1024) begin : g_bad_h_tot
    $error("pong_vga_sync: H_TOT exceeds 1024");
  end
  if (V_TOT > 1024) begin : g_bad_v_tot
    $error("pong_vga_sync: V_TOT exceeds 1024");
  end
  if (DIV < 2) begin : g_bad_div
    $error("pong_vga_sync: DIV must be at least 2");
  end

  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISP);
  localparam logic [9:0] V_VIS    = 10'(V_DISP);
  localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_cnt, div_nxt;
  logic [9:0]    h_nxt, v_nxt;
  logic          hs_nxt, vs_nxt, vo_nxt;
  logic          hs_r, vs_r, vo_r;

  always_comb begin
    p_tick = (div_cnt == DIV_LAST);
    l_tick = p_tick && (pixel_x == H_LAST);
    f_tick = l_tick && (pixel_y == V_LAST);

    div_nxt = p_tick ? '0 : div_cnt + DW'(1);
    h_nxt   = pixel_x;
    v_nxt   = pixel_y;
    if (p_tick) begin
      h_nxt = (pixel_x == H_LAST) ? 10'd0 : pixel_x + 10'd1;
    end
    if (l_tick) begin
      v_nxt = (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
    end

    // Decode from next-state counters so the registered flags line up with pixel_x/pixel_y.
    hs_nxt = ((h_nxt >= HS_START) && (h_nxt <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_nxt = ((v_nxt >= VS_START) && (v_nxt <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    vo_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      pixel_x <= 10'd0;
      pixel_y <= 10'd0;
      hs_r    <= ~SYNC_POL;
      vs_r    <= ~SYNC_POL;
      vo_r    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      pixel_x <= h_nxt;
      pixel_y <= v_nxt;
      hs_r    <= hs_nxt;
      vs_r    <= vs_nxt;
      vo_r    <= vo_nxt;
    end
  end

`ifdef PONG_SYNC_PIPE_EN
  // One extra stage to match the synchronous font ROM read latency downstream.
  logic hs_p, vs_p, vo_p;

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_p <= ~SYNC_POL;
      vs_p <= ~SYNC_POL;
      vo_p <= 1'b0;
    end else begin
      hs_p <= hs_r;
      vs_p <= vs_r;
      vo_p <= vo_r;
    end
  end

  assign hsync    = hs_p;
  assign vsync    = vs_p;
  assign video_on = vo_p;
`else
  assign hsync    = hs_r;
  assign vsync    = vs_r;
  assign video_on = vo_r;
`endif

endmodule

// File: tb/tb_pong_vga_sync.sv
module tb_pong_vga_sync;

`ifdef PONG_SYNC_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // Instance A: standard 640x480 timing, active-low sync.
  logic [9:0] a_x, a_y;
  logic a_p, a_l, a_f, a_hs, a_vs, a_vo;
  pong_vga_sync u_a (
    .clk(clk), .reset(reset), .pixel_x(a_x), .pixel_y(a_y),
    .p_tick(a_p), .l_tick(a_l), .f_tick(a_f),
    .hsync(a_hs), .vsync(a_vs), .video_on(a_vo)
  );

  // Instance B: tiny geometry, DIV=2, active-high sync, so whole frames fit in a short run.
  logic [9:0] b_x, b_y;
  logic b_p, b_l, b_f, b_hs, b_vs, b_vo;
  pong_vga_sync #(
    .DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISP(6), .V_FP(2), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) u_b (
    .clk(clk), .reset(reset), .pixel_x(b_x), .pixel_y(b_y),
    .p_tick(b_p), .l_tick(b_l), .f_tick(b_f),
    .hsync(b_hs), .vsync(b_vs), .video_on(b_vo)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;            // clk edges since the last edge that sampled reset high
  bit valid = 1'b0;     // true once at least one reset edge has been seen
  int a_hs_cnt = 0;     // active hsync clocks on A during the first line after release
  int a_l_cnt = 0;      // l_tick pulses on A during that line
  int b_last_f = -1;    // k of the previous B f_tick within the current run

  // Expected outputs derived from elapsed clocks: pixel index = k / DIV, then
  // split into (h, v) by the line and frame totals.
  // Packed as {x[9:0], y[9:0], p, l, f, hsync, vsync, video_on}.
  function automatic logic [25:0] model(input int kc, input int dv,
                                        input int hd, input int hf, input int hs, input int hb,
                                        input int vd, input int vf, input int vs, input int vb,
                                        input bit pol);
    int ht, vt, n, h, v, kk, sh, sv;
    logic p, l, f, hsy, vsy, vo;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    n  = kc / dv;
    h  = n % ht;
    v  = (n / ht) % vt;
    p  = ((kc % dv) == dv - 1);
    l  = p && (h == ht - 1);
    f  = l && (v == vt - 1);
    kk = kc - PIPE;
    if (kk <= 0) begin
      hsy = ~pol;
      vsy = ~pol;
      vo  = 1'b0;
    end else begin
      sh  = (kk / dv) % ht;
      sv  = ((kk / dv) / ht) % vt;
      hsy = (sh >= hd + hf && sh < hd + hf + hs) ? pol : ~pol;
      vsy = (sv >= vd + vf && sv < vd + vf + vs) ? pol : ~pol;
      vo  = (sh < hd) && (sv < vd);
    end
    return {10'(h), 10'(v), p, l, f, hsy, vsy, vo};
  endfunction

  task automatic tick();
    logic [25:0] exp_a, exp_b, got_a, got_b;
    @(posedge clk);
    if (reset) begin
      k = 0;
      valid = 1'b1;
      b_last_f = -1;
    end else begin
      k++;
    end
    @(negedge clk);
    if (valid) begin
      exp_a = model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      exp_b = model(k, 2, 8, 2, 3, 2, 6, 2, 2, 1, 1'b1);
      got_a = {a_x, a_y, a_p, a_l, a_f, a_hs, a_vs, a_vo};
      got_b = {b_x, b_y, b_p, b_l, b_f, b_hs, b_vs, b_vo};
      checks++;
      assert (got_a === exp_a) else begin
        errors++;
        $error("FAIL inst_a k=%0d: got %h expected %h (x,y,p,l,f,hs,vs,vo)", k, got_a, exp_a);
      end
      checks++;
      assert (got_b === exp_b) else begin
        errors++;
        $error("FAIL inst_b k=%0d: got %h expected %h (x,y,p,l,f,hs,vs,vo)", k, got_b, exp_b);
      end
      if (b_f) begin
        if (b_last_f >= 0) begin
          checks++;
          assert ((k - b_last_f) === 330) else begin
            errors++;
            $error("FAIL b_frame_spacing: got %0d expected %0d", k - b_last_f, 330);
          end
        end
        b_last_f = k;
      end
    end
  endtask

  initial begin
    // Reset held for 5 clks, then one full line of A plus margin.
    reset = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    for (int i = 1; i <= 3300; i++) begin
      tick();
      if (k >= 1 && k <= 3200) begin
        if (a_hs == 1'b0) a_hs_cnt++;
        if (a_l) a_l_cnt++;
      end
    end
    checks++;
    assert (a_hs_cnt === 384) else begin
      errors++;
      $error("FAIL a_hsync_width: got %0d expected %0d", a_hs_cnt, 384);
    end
    checks++;
    assert (a_l_cnt === 1) else begin
      errors++;
      $error("FAIL a_l_tick_count: got %0d expected %0d", a_l_cnt, 1);
    end

    // Random mid-line / mid-frame resets, each followed by a random free run.
    for (int r = 0; r < 5; r++) begin
      reset = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      reset = 1'b0;
      repeat ($urandom_range(150, 900)) tick();
    end

    // Long free run: several B frames for f_tick spacing and A past its hsync window.
    repeat (3000) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
